// File: rtl/serial_subtractor_4bit_pkg.sv
// rtl/serial_subtractor_4bit_pkg.sv - shared state encoding and sizing helpers
package serial_subtractor_4bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// rtl/serial_subtractor_4bit.sv - bit-serial unsigned subtractor, LSB first, one full adder
module serial_subtractor_4bit
    import serial_subtractor_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             sum;
    logic             carry_next;

    assign last = (cnt == CW'(WIDTH - 1));
    assign d    = res;

    // Subtraction as a + ~b + 1: the +1 comes from presetting the carry.
    full_adder u_fa (
        .a    (sa[0]),
        .b    (~sb[0]),
        .cin  (c),
        .s    (sum),
        .cout (carry_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last)  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bout  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        c    <= 1'b1;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    c   <= carry_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {sum, res[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    // Final carry is known on the last shift; borrow is its inverse.
                    if (last) begin
                        done <= 1'b1;
                        bout <= ~carry_next;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
